// File: rtl/block_pack.sv
// Collects D_WIDTH-bit words into N_WORDS-word blocks, low word first, behind valid/ready on both sides.
// Optional BLOCK_PACK_LAST_EN adds i_last / o_nwords for zero-filled partial-block flushes.
module block_pack #(
   parameter int D_WIDTH = 128,
   parameter int N_WORDS = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rstn,
   input  logic                       i_valid,
   input  logic [D_WIDTH-1:0]         i_data,
`ifdef BLOCK_PACK_LAST_EN
   input  logic                       i_last,
`endif
   output logic                       o_ready,
   output logic                       o_valid,
   output logic [D_WIDTH*N_WORDS-1:0] o_data,
`ifdef BLOCK_PACK_LAST_EN
   output logic [2:0]                 o_nwords,
`endif
   input  logic                       i_ready
);

   localparam int BW = D_WIDTH * N_WORDS;
   localparam int CW = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;

   logic [BW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic [BW-1:0] dat_q, dat_d;
   logic          vld_q, vld_d;
`ifdef BLOCK_PACK_LAST_EN
   logic [2:0]    nw_q, nw_d;
   logic [2:0]    pnw_q, pnw_d;
`endif

   logic          accept;
   logic          drain;
   logic          complete;
   logic [BW-1:0] merged;
   logic [2:0]    cur_nw;

   always_comb begin
      acc_d  = acc_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      dat_d  = dat_q;
      vld_d  = vld_q;
`ifdef BLOCK_PACK_LAST_EN
      nw_d   = nw_q;
      pnw_d  = pnw_q;
`endif

      accept = i_valid && !pend_q;
      drain  = vld_q && i_ready;
      cur_nw = 3'(cnt_q) + 3'd1;

      merged = acc_q;
      for (int unsigned k = 0; k < N_WORDS; k++) begin
         if (cnt_q == CW'(k)) merged[k*D_WIDTH +: D_WIDTH] = i_data;
      end

`ifdef BLOCK_PACK_LAST_EN
      complete = accept && ((cnt_q == CW'(N_WORDS-1)) || i_last);
`else
      complete = accept && (cnt_q == CW'(N_WORDS-1));
`endif

      if (drain) vld_d = 1'b0;

      // Unused slots stay zero because the accumulator is cleared whenever its block leaves it.
      if (pend_q && drain) begin
         dat_d  = acc_q;
         vld_d  = 1'b1;
         acc_d  = '0;
         pend_d = 1'b0;
`ifdef BLOCK_PACK_LAST_EN
         nw_d   = pnw_q;
`endif
      end else if (complete) begin
         cnt_d = '0;
         if (!vld_q || i_ready) begin
            dat_d = merged;
            vld_d = 1'b1;
            acc_d = '0;
`ifdef BLOCK_PACK_LAST_EN
            nw_d  = cur_nw;
`endif
         end else begin
            acc_d  = merged;
            pend_d = 1'b1;
`ifdef BLOCK_PACK_LAST_EN
            pnw_d  = cur_nw;
`endif
         end
      end else if (accept) begin
         acc_d = merged;
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         pend_q <= 1'b0;
         dat_q  <= '0;
         vld_q  <= 1'b0;
`ifdef BLOCK_PACK_LAST_EN
         nw_q   <= '0;
         pnw_q  <= '0;
`endif
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         dat_q  <= dat_d;
         vld_q  <= vld_d;
`ifdef BLOCK_PACK_LAST_EN
         nw_q   <= nw_d;
         pnw_q  <= pnw_d;
`endif
      end
   end

   assign o_ready  = !pend_q;
   assign o_valid  = vld_q;
   assign o_data   = dat_q;
`ifdef BLOCK_PACK_LAST_EN
   assign o_nwords = nw_q;
`else
   logic unused_nw;
   assign unused_nw = ^cur_nw;
`endif

endmodule
